// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end.
// Issues sequential word fetches to a synchronous instruction memory, tags each
// grant with its PC, and buffers returned words in an in-order FIFO that decode
// drains with a valid/ready handshake. A redirect flushes the FIFO, restarts
// fetch at the new PC and turns every outstanding read into one to be dropped.
// Issue credit covers buffered + in-flight + to-be-dropped reads, so the FIFO
// can never overflow and the PC tag FIFO never holds more than DEPTH tags.
module instr_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;        // counters reach DEPTH inclusive
   localparam int unsigned SW = CW + 2;        // headroom for the credit sum
   localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] tag_rd_ptr_q, tag_rd_ptr_d;
   logic [AW-1:0] tag_wr_ptr_q, tag_wr_ptr_d;

   // Decode FIFO payload and the PC tags of outstanding reads.
   logic [31:0] word_mem [DEPTH];
   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] tag_mem  [DEPTH];

   logic [SW-1:0] credit_used;
   logic          grant;
   logic          resp_drop;
   logic          resp_push;
   logic          pop;

   assign imem_addr   = fetch_pc_q;
   assign instr_valid = (count_q != '0);
   assign instr       = instr_valid ? word_mem[rd_ptr_q] : NOP_WORD;
   assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : 32'h0000_0000;

   // Request gating and the per-cycle events derived from the handshakes.
   always_comb begin
      credit_used = SW'(count_q) + SW'(inflight_q) + SW'(discard_q);
      imem_req    = !rst && !redirect && (credit_used < DEPTH_S);
      grant       = imem_req && imem_gnt;
      // Stale responses are consumed first; a response in a redirect cycle is
      // also dropped, and the redirect arithmetic below accounts for it.
      resp_drop   = imem_rvalid && (discard_q != '0);
      resp_push   = imem_rvalid && !resp_drop && !redirect;
      pop         = instr_valid && instr_ready && !redirect;
   end

   // Next-state for fetch PC, FIFO bookkeeping and read accounting.
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      count_d      = count_q;
      inflight_d   = inflight_q;
      discard_d    = discard_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      tag_wr_ptr_d = tag_wr_ptr_q;
      tag_rd_ptr_d = tag_rd_ptr_q;

      // Tags follow memory order regardless of redirects: one in per grant,
      // one out per response whether that response is kept or dropped.
      if (grant) begin
         tag_wr_ptr_d = tag_wr_ptr_q + AW'(1);
      end
      if (imem_rvalid) begin
         tag_rd_ptr_d = tag_rd_ptr_q + AW'(1);
      end

      if (redirect) begin
         fetch_pc_d = redirect_pc & ~32'h0000_0003;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         // Everything still outstanding becomes stale, less the response
         // that completes (and is dropped) in this very cycle.
         discard_d  = discard_q + inflight_q - CW'(imem_rvalid);
         inflight_d = '0;
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         inflight_d = inflight_q + CW'(grant) - CW'(resp_push);
         if (resp_drop) begin
            discard_d = discard_q - CW'(1);
         end
         if (resp_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(resp_push) - CW'(pop);
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q   <= RESET_PC;
         count_q      <= '0;
         inflight_q   <= '0;
         discard_q    <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         tag_rd_ptr_q <= '0;
         tag_wr_ptr_q <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         count_q      <= count_d;
         inflight_q   <= inflight_d;
         discard_q    <= discard_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         tag_rd_ptr_q <= tag_rd_ptr_d;
         tag_wr_ptr_q <= tag_wr_ptr_d;
      end
   end

   // Storage writes: tag on grant, word plus its tag on an accepted response.
   always_ff @(posedge clk) begin
      if (grant) begin
         tag_mem[tag_wr_ptr_q] <= fetch_pc_q;
      end
      if (resp_push) begin
         word_mem[wr_ptr_q] <= imem_rdata;
         pc_mem[wr_ptr_q]   <= tag_mem[tag_rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a behavioural memory with configurable grant
// pattern and in-order variable latency, a stream-level reference (the decode
// stream is RESET_PC or the last redirect target counting up by 4), and a
// monitor that checks every consumed instruction against that stream.
module tb_instr_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   always #5 clk = ~clk;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory model ----------------
   // Phase within each cycle (after negedge): +0 stimulus, +1 memory drives,
   // +2 reactive stimulus, +3 memory samples grants, +4 monitor.
   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   mreq_t       pend_q[$];
   mreq_t       new_req;
   int unsigned last_due = 0;
   int unsigned mem_lat  = 1;
   int          gnt_mode = 0;   // 0 always, 1 toggle, 2 random
   int          lat_mode = 0;   // 0 fixed, 1 random 1..3
   int unsigned lat_fixed = 1;
   logic        gnt_tog = 1'b0;

   always @(negedge clk) begin
      #1;
      if (rst) begin
         pend_q.delete();
         last_due    = 0;
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
         imem_gnt    = 1'b0;
      end else begin
         if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q[0].addr);
            pend_q.delete(0);
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
         end
         case (gnt_mode)
            0:       imem_gnt = 1'b1;
            1:       begin gnt_tog = !gnt_tog; imem_gnt = gnt_tog; end
            default: imem_gnt = ($urandom_range(0, 2) != 0);
         endcase
         #2;
         if (imem_req && imem_gnt) begin
            mem_lat = (lat_mode == 0) ? lat_fixed : $urandom_range(1, 3);
            new_req.addr = imem_addr;
            new_req.due  = cyc + mem_lat;
            if (new_req.due <= last_due) new_req.due = last_due + 1;
            last_due = new_req.due;
            pend_q.push_back(new_req);
         end
      end
   end

   // ---------------- reference stream ----------------
   logic [31:0] exp_q[$];

   task automatic restart_stream(input logic [31:0] a);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(a + 32'(4 * i));
   endtask

   task automatic do_redirect(input logic [31:0] t);
      redirect    = 1'b1;
      redirect_pc = t;
      restart_stream(t & ~32'h0000_0003);
   endtask

   // ---------------- monitor ----------------
   logic [31:0] exp_fetch = RESET_PC;
   logic [31:0] exp_pc;
   logic        mon_grant;
   logic        mon_pop;
   int          gsince = 0;
   int          psince = 0;
   int          pops_total = 0;

   always @(negedge clk) begin
      #4;
      if (rst) begin
         gsince    = 0;
         psince    = 0;
         exp_fetch = RESET_PC;
      end else begin
         mon_grant = imem_req && imem_gnt;
         mon_pop   = instr_valid && instr_ready && !redirect;
         if (redirect) chk_b("no_req_on_redirect", imem_req, 1'b0);
         if (!instr_valid) begin
            chk("empty_instr", instr, NOP_WORD);
            chk("empty_pc", instr_pc, 32'h0);
         end
         if (mon_grant) begin
            chk("fetch_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            gsince++;
         end
         if (mon_pop) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard_empty: got pc %h, expected no instruction", instr_pc);
            end else begin
               exp_pc = exp_q.pop_front();
               exp_q.push_back(exp_q[exp_q.size() - 1] + 32'd4);
               chk("instr_pc", instr_pc, exp_pc);
               chk("instr_word", instr, mem_word(exp_pc));
            end
            psince++;
            pops_total++;
         end
         // Post-redirect grants are exactly the buffered + in-flight entries
         // not yet consumed.
         chk_b("credit_invariant", (gsince - psince) <= DEPTH, 1'b1);
         chk_b("mem_outstanding", pend_q.size() <= DEPTH, 1'b1);
         if (redirect) begin
            gsince    = 0;
            psince    = 0;
            exp_fetch = redirect_pc & ~32'h0000_0003;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst      = 1'b1;
         redirect = 1'b0;
      end
      restart_stream(RESET_PC);
      #4;
      chk_b("rst_req", imem_req, 1'b0);
      chk_b("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, NOP_WORD);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_addr", imem_addr, RESET_PC);
   endtask

   initial begin
      int grants;
      int r;

      // Latency and throughput from reset.
      gnt_mode = 0; lat_mode = 0; lat_fixed = 1;
      do_reset(3);
      @(negedge clk); rst = 1'b0; instr_ready = 1'b1;
      #4; chk_b("t1_first_req", imem_req, 1'b1); chk_b("t1_c0_valid", instr_valid, 1'b0);
      @(negedge clk); #4; chk_b("t1_c1_valid", instr_valid, 1'b0);
      @(negedge clk); #4; chk_b("t1_c2_valid", instr_valid, 1'b1); chk("t1_c2_pc", instr_pc, RESET_PC);
      for (int k = 1; k < 12; k++) begin
         @(negedge clk); #4;
         chk_b("t1_stream_valid", instr_valid, 1'b1);
         chk("t1_stream_pc", instr_pc, RESET_PC + 32'(4 * k));
      end

      // Decode stalled: credit limits outstanding fetches to DEPTH.
      do_reset(2);
      @(negedge clk); rst = 1'b0; instr_ready = 1'b0; grants = 0;
      #4; if (imem_req && imem_gnt) grants++;
      for (int k = 1; k < 10; k++) begin
         @(negedge clk); #4;
         if (imem_req && imem_gnt) grants++;
      end
      chk("t2_grants", grants, DEPTH);
      chk_b("t2_req_low", imem_req, 1'b0);
      chk_b("t2_valid", instr_valid, 1'b1);
      chk("t2_head", instr_pc, RESET_PC);
      @(negedge clk); instr_ready = 1'b1;
      repeat (12) @(negedge clk);

      // Redirect with 2 buffered, 2 in flight and a response in the same cycle.
      lat_fixed = 2;
      do_reset(2);
      @(negedge clk); rst = 1'b0; instr_ready = 1'b0;
      repeat (4) @(negedge clk);
      instr_ready = 1'b1;
      do_redirect(32'h0000_1003);
      #4; chk_b("t3_rvalid_same_cycle", imem_rvalid, 1'b1); chk_b("t3_valid_before", instr_valid, 1'b1);
      @(negedge clk); redirect = 1'b0;
      #4; chk_b("t3_flushed", instr_valid, 1'b0); chk_b("t3_req", imem_req, 1'b1); chk("t3_addr", imem_addr, 32'h0000_1000);
      repeat (12) @(negedge clk);

      // Back-to-back redirects with slow memory; the last target wins.
      lat_fixed = 3;
      do_reset(2);
      @(negedge clk); rst = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      @(negedge clk); do_redirect(32'h0000_2000);
      #4; chk_b("t4_no_rvalid", imem_rvalid, 1'b0);
      @(negedge clk); do_redirect(32'h0000_3006);
      #4; chk_b("t4_valid", instr_valid, 1'b0);
      @(negedge clk); redirect = 1'b0;
      #4; chk("t4_addr", imem_addr, 32'h0000_3004); chk_b("t4_req", imem_req, 1'b1);
      repeat (15) @(negedge clk);

      // Randomized phases: grant pattern, latency, stalls and redirects.
      for (int ph = 0; ph < 4; ph++) begin
         gnt_mode  = (ph == 0) ? 1 : (ph == 2) ? 0 : 2;
         lat_mode  = (ph == 2) ? 0 : 1;
         lat_fixed = 1;
         for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            rst = 1'b0;
            instr_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 39);
            if (r < 2) do_redirect($urandom);
            else redirect = 1'b0;
            if (r == 2) begin
               #2;
               if (imem_rvalid) do_redirect($urandom);
            end
         end
      end

      // One-cycle reset in the middle of a stalled stream.
      @(negedge clk); redirect = 1'b0;
      gnt_mode = 0; lat_mode = 0; lat_fixed = 1; instr_ready = 1'b1;
      repeat (5) @(negedge clk);
      @(negedge clk); instr_ready = 1'b0;
      repeat (3) @(negedge clk);
      #4; chk_b("t6_buffered", instr_valid, 1'b1);
      @(negedge clk); rst = 1'b1; restart_stream(RESET_PC);
      @(negedge clk); rst = 1'b0;
      #4;
      chk("t6_instr", instr, NOP_WORD);
      chk_b("t6_valid", instr_valid, 1'b0);
      chk("t6_addr", imem_addr, RESET_PC);
      chk_b("t6_req", imem_req, 1'b1);
      @(negedge clk); instr_ready = 1'b1;
      repeat (12) @(negedge clk);

      #4;
      chk_b("progress", pops_total > 200, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
